// File: rtl/aw_thread_scheduler_pkg.sv
// Shared types and constants for the Another World thread scheduler.
// Holds the channel command codes, the scheduler states and the reserved PC markers.
package aw_thread_scheduler_pkg;

    typedef enum logic [1:0] {
        CHAN_RESUME = 2'd0,
        CHAN_PAUSE  = 2'd1,
        CHAN_KILL   = 2'd2,
        CHAN_NOP    = 2'd3
    } chan_type_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPLY    = 3'd1,
        S_SCAN     = 3'd2,
        S_DISPATCH = 3'd3,
        S_WAIT     = 3'd4,
        S_DONE     = 3'd5
    } sched_state_e;

    // PC markers are the top two codes of the address space, at any PC width.
    function automatic logic [31:0] pc_inactive(input int pc_w);
        return (32'h1 << pc_w) - 32'd1;
    endfunction

    function automatic logic [31:0] pc_kill(input int pc_w);
        return (32'h1 << pc_w) - 32'd2;
    endfunction

endpackage

// File: rtl/aw_thread_scheduler_range_walker.sv
// updateChannel range walker: latches a thread range and command, then emits
// one request-write strobe per thread, first..last, one per cycle.
module aw_thread_scheduler_range_walker
    import aw_thread_scheduler_pkg::*;
#(
    parameter int TID_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chan_valid,
    input  logic [TID_W-1:0] chan_first,
    input  logic [TID_W-1:0] chan_last,
    input  logic [1:0]       chan_type,
    output logic             busy,
    output logic             wr_en,
    output logic [TID_W-1:0] wr_thread,
    output chan_type_e       wr_type
);

    logic [TID_W-1:0] cur;
    logic [TID_W-1:0] last_tid;
    chan_type_e       kind;
    logic             nop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            cur      <= '0;
            last_tid <= '0;
            kind     <= CHAN_NOP;
            nop      <= 1'b1;
        end else if (!busy) begin
            if (chan_valid) begin
                busy     <= 1'b1;
                cur      <= chan_first;
                last_tid <= chan_last;
                kind     <= chan_type_e'(chan_type);
                // An empty range or a no-op command still occupies the walker for one cycle.
                nop      <= (chan_first > chan_last) || (chan_type == CHAN_NOP);
            end
        end else if (nop || (cur == last_tid)) begin
            busy <= 1'b0;
        end else begin
            cur <= cur + 1'b1;
        end
    end

    assign wr_en     = busy && !nop;
    assign wr_thread = cur;
    assign wr_type   = kind;

endmodule

// File: rtl/aw_thread_scheduler.sv
// Another World VM thread scheduler: per-thread PC/pause state, frame-start request
// application, in-order dispatch of runnable threads and setVec/updateChannel side effects.
module aw_thread_scheduler
    import aw_thread_scheduler_pkg::*;
#(
    parameter  int NUM_THREADS = 64,
    parameter  int PC_W        = 16,
    localparam int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    output logic             frame_done,
    output logic             run_valid,
    output logic [TID_W-1:0] run_thread,
    output logic [PC_W-1:0]  run_pc,
    input  logic             run_accept,
    input  logic             yield_valid,
    input  logic             yield_kill,
    input  logic [PC_W-1:0]  yield_pc,
    input  logic             setvec_valid,
    output logic             setvec_ready,
    input  logic [TID_W-1:0] setvec_thread,
    input  logic [PC_W-1:0]  setvec_pc,
    input  logic             chan_valid,
    input  logic [TID_W-1:0] chan_first,
    input  logic [TID_W-1:0] chan_last,
    input  logic [1:0]       chan_type,
    output logic             chan_busy
);

    localparam logic [PC_W-1:0]  INACTIVE = PC_W'(pc_inactive(PC_W));
    localparam logic [PC_W-1:0]  KILL     = PC_W'(pc_kill(PC_W));
    localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);

    logic [PC_W-1:0]        pc     [NUM_THREADS];
    logic [PC_W-1:0]        req_pc [NUM_THREADS];
    logic [NUM_THREADS-1:0] paused;
    logic [NUM_THREADS-1:0] req_paused;

    sched_state_e     state;
    logic [TID_W-1:0] idx;

    logic             walk_we;
    logic [TID_W-1:0] walk_thread;
    chan_type_e       walk_type;

    logic             setvec_fire;
    logic             apply_hit;
    logic             runnable;
    logic             pc_we;
    logic [PC_W-1:0]  pc_wdata;

    aw_thread_scheduler_range_walker #(
        .TID_W (TID_W)
    ) u_walker (
        .clk        (clk),
        .reset      (reset),
        .chan_valid (chan_valid),
        .chan_first (chan_first),
        .chan_last  (chan_last),
        .chan_type  (chan_type),
        .busy       (chan_busy),
        .wr_en      (walk_we),
        .wr_thread  (walk_thread),
        .wr_type    (walk_type)
    );

    assign setvec_ready = !chan_busy;
    assign setvec_fire  = setvec_valid && setvec_ready;
    assign apply_hit    = (state == S_APPLY) && (req_pc[idx] != INACTIVE);
    assign runnable     = (pc[idx] != INACTIVE) && !paused[idx];

    // Live PC has two writers, both addressed by idx and never active in the same state.
    always_comb begin
        pc_we    = 1'b0;
        pc_wdata = req_pc[idx];
        if (apply_hit) begin
            pc_we    = 1'b1;
            pc_wdata = (req_pc[idx] == KILL) ? INACTIVE : req_pc[idx];
        end else if ((state == S_WAIT) && yield_valid) begin
            pc_we    = 1'b1;
            pc_wdata = yield_kill ? INACTIVE : yield_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc[i] <= (i == 0) ? '0 : INACTIVE;
            end
        end else if (pc_we) begin
            pc[idx] <= pc_wdata;
        end
    end

    // Request writes outrank the APPLY clear so a late request survives into the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                req_pc[i] <= INACTIVE;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (setvec_fire && (setvec_thread == TID_W'(i))) begin
                    req_pc[i] <= setvec_pc;
                end else if (walk_we && (walk_type == CHAN_KILL) && (walk_thread == TID_W'(i))) begin
                    req_pc[i] <= KILL;
                end else if (apply_hit && (idx == TID_W'(i))) begin
                    req_pc[i] <= INACTIVE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_paused <= '0;
        end else if (walk_we) begin
            if (walk_type == CHAN_RESUME) begin
                req_paused[walk_thread] <= 1'b0;
            end else if (walk_type == CHAN_PAUSE) begin
                req_paused[walk_thread] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paused <= '0;
        end else if (state == S_APPLY) begin
            paused[idx] <= req_paused[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            run_valid  <= 1'b0;
            run_thread <= '0;
            run_pc     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state <= S_APPLY;
                        idx   <= '0;
                    end
                end
                S_APPLY: begin
                    if (idx == LAST_TID) begin
                        state <= S_SCAN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (runnable) begin
                        state      <= S_DISPATCH;
                        run_valid  <= 1'b1;
                        run_thread <= idx;
                        run_pc     <= pc[idx];
                    end else if (idx == LAST_TID) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DISPATCH: begin
                    if (run_accept) begin
                        state     <= S_WAIT;
                        run_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (yield_valid) begin
                        if (idx == LAST_TID) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= S_SCAN;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aw_thread_scheduler.sv
// Scoreboard bench for aw_thread_scheduler: a transaction-level thread model predicts each
// frame's dispatch order, and a core emulator accepts and yields the offered threads.
module tb_aw_thread_scheduler;

    localparam int N     = 64;
    localparam int TID_W = 6;
    localparam int PC_W  = 16;
    localparam logic [15:0] INACTIVE = 16'hFFFF;
    localparam logic [15:0] KILL     = 16'hFFFE;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_start;
    logic             frame_done;
    logic             run_valid;
    logic [TID_W-1:0] run_thread;
    logic [PC_W-1:0]  run_pc;
    logic             run_accept;
    logic             yield_valid;
    logic             yield_kill;
    logic [PC_W-1:0]  yield_pc;
    logic             setvec_valid;
    logic             setvec_ready;
    logic [TID_W-1:0] setvec_thread;
    logic [PC_W-1:0]  setvec_pc;
    logic             chan_valid;
    logic [TID_W-1:0] chan_first;
    logic [TID_W-1:0] chan_last;
    logic [1:0]       chan_type;
    logic             chan_busy;

    always #5 clk = ~clk;

    aw_thread_scheduler #(
        .NUM_THREADS (N),
        .PC_W        (PC_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .run_valid     (run_valid),
        .run_thread    (run_thread),
        .run_pc        (run_pc),
        .run_accept    (run_accept),
        .yield_valid   (yield_valid),
        .yield_kill    (yield_kill),
        .yield_pc      (yield_pc),
        .setvec_valid  (setvec_valid),
        .setvec_ready  (setvec_ready),
        .setvec_thread (setvec_thread),
        .setvec_pc     (setvec_pc),
        .chan_valid    (chan_valid),
        .chan_first    (chan_first),
        .chan_last     (chan_last),
        .chan_type     (chan_type),
        .chan_busy     (chan_busy)
    );

    typedef struct {
        bit          done;
        int          tid;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_pc[N];
    logic [15:0] m_req_pc[N];
    bit          m_paused[N];
    bit          m_req_paused[N];
    logic [15:0] y_pc[N];
    bit          y_kill[N];
    int          hook;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pc[i]         = (i == 0) ? 16'h0000 : INACTIVE;
            m_req_pc[i]     = INACTIVE;
            m_paused[i]     = 1'b0;
            m_req_paused[i] = 1'b0;
        end
    endtask

    task automatic setvec(input int tid, input logic [15:0] pc);
        check("setvec_ready", setvec_ready, 1);
        setvec_valid  = 1'b1;
        setvec_thread = TID_W'(tid);
        setvec_pc     = pc;
        @(negedge clk);
        setvec_valid  = 1'b0;
        m_req_pc[tid] = pc;
    endtask

    task automatic chan(input int first, input int last, input int kind, input int exp_busy,
                        input string tag);
        int cnt;
        chan_valid = 1'b1;
        chan_first = TID_W'(first);
        chan_last  = TID_W'(last);
        chan_type  = 2'(kind);
        @(negedge clk);
        chan_valid = 1'b0;
        cnt = 0;
        while (chan_busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check(tag, cnt, exp_busy);
        if (first <= last && kind != 3) begin
            for (int i = first; i <= last; i++) begin
                if (kind == 0) m_req_paused[i] = 1'b0;
                if (kind == 1) m_req_paused[i] = 1'b1;
                if (kind == 2) m_req_pc[i] = KILL;
            end
        end
    endtask

    task automatic run_frame(input int exp_len);
        exp_t e;
        int   cnt;
        int   tid;
        bit   fin;
        for (int i = 0; i < N; i++) begin
            if (m_req_pc[i] !== INACTIVE) begin
                m_pc[i]     = (m_req_pc[i] == KILL) ? INACTIVE : m_req_pc[i];
                m_req_pc[i] = INACTIVE;
            end
            m_paused[i] = m_req_paused[i];
        end
        for (int i = 0; i < N; i++) begin
            if (m_pc[i] !== INACTIVE && !m_paused[i]) exp_q.push_back('{done: 1'b0, tid: i, pc: m_pc[i]});
        end
        exp_q.push_back('{done: 1'b1, tid: 0, pc: 16'h0000});
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cnt = 1;
        fin = 1'b0;
        while (!fin) begin
            if (frame_done || run_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {run_valid, frame_done}, 0);
                    fin = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_done", frame_done, e.done);
                    if (frame_done) begin
                        if (exp_len > 0) check("done_latency", cnt, exp_len);
                        @(negedge clk);
                        check("done_one_cycle", frame_done, 0);
                        exp_q.delete();
                        fin = 1'b1;
                    end else begin
                        tid = int'(run_thread);
                        check("run_thread", run_thread, e.tid);
                        check("run_pc", run_pc, e.pc);
                        if (hook == 4) begin
                            frame_start = 1'b1;
                            @(negedge clk);
                            frame_start = 1'b0;
                            repeat (2) @(negedge clk);
                            check("dispatch_hold_valid", run_valid, 1);
                            check("dispatch_hold_thread", run_thread, e.tid);
                            hook = 0;
                        end
                        run_accept = 1'b1;
                        @(negedge clk);
                        run_accept = 1'b0;
                        check("accept_drops_valid", run_valid, 0);
                        if (hook == 1) begin
                            setvec(5, 16'h4000);
                            hook = 0;
                        end else if (hook == 2) begin
                            chan(0, 63, 2, 64, "busy_kill_all");
                            hook = 0;
                        end
                        if (hook == 3) begin
                            reset = 1'b0;
                            #1;
                            check("rst_wait_valid", run_valid, 0);
                            check("rst_wait_done", frame_done, 0);
                            check("rst_wait_thread", run_thread, 0);
                            check("rst_wait_ready", setvec_ready, 1);
                            @(negedge clk);
                            reset = 1'b1;
                            model_reset();
                            exp_q.delete();
                            hook = 0;
                            fin  = 1'b1;
                        end else begin
                            yield_valid = 1'b1;
                            yield_kill  = y_kill[tid];
                            yield_pc    = y_pc[tid];
                            m_pc[tid]   = y_kill[tid] ? INACTIVE : y_pc[tid];
                            @(negedge clk);
                            yield_valid = 1'b0;
                        end
                    end
                end
            end else begin
                @(negedge clk);
                cnt++;
                if (cnt > 5000) begin
                    check("frame_timeout", cnt, 0);
                    exp_q.delete();
                    fin = 1'b1;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        frame_start = 1'b0; run_accept = 1'b0; yield_valid = 1'b0; yield_kill = 1'b0;
        yield_pc = '0; setvec_valid = 1'b0; setvec_thread = '0; setvec_pc = '0;
        chan_valid = 1'b0; chan_first = '0; chan_last = '0; chan_type = '0;
        hook = 0;
        for (int i = 0; i < N; i++) begin
            y_pc[i]   = 16'h1000 + 16'(i * 16);
            y_kill[i] = 1'b0;
        end
        model_reset();
        #1;
        check("rst_run_valid", run_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_chan_busy", chan_busy, 0);
        check("rst_setvec_ready", setvec_ready, 1);
        check("rst_run_pc", run_pc, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Thread 0 starts at PC 0 and resumes at its yield PC.
        y_pc[0] = 16'h0123;
        run_frame(0);
        run_frame(0);

        // setVec while thread 0 runs becomes visible next frame.
        hook = 1;
        run_frame(0);
        run_frame(0);

        // Pause and resume a range.
        setvec(3, 16'h0300); setvec(4, 16'h0400); setvec(6, 16'h0600); setvec(7, 16'h0700);
        run_frame(0);
        chan(3, 6, 1, 4, "busy_pause_3_6");
        run_frame(0);
        chan(3, 6, 0, 4, "busy_resume_3_6");
        run_frame(0);

        // Kill everything from inside thread 0, then an empty frame.
        hook = 2;
        run_frame(0);
        run_frame(2 * N + 1);

        // Stray handshakes outside their states are ignored.
        yield_valid = 1'b1; run_accept = 1'b1;
        @(negedge clk);
        yield_valid = 1'b0; run_accept = 1'b0;
        check("idle_stray_valid", run_valid, 0);
        run_frame(2 * N + 1);

        // Killed thread stays dead until setVec; degenerate channel commands change nothing.
        setvec(0, 16'h0100); setvec(2, 16'h0200);
        y_kill[2] = 1'b1;
        run_frame(0);
        run_frame(0);
        chan(9, 4, 1, 1, "busy_empty_range");
        chan(0, 63, 3, 1, "busy_nop");
        run_frame(0);
        setvec(2, 16'h0300);
        y_kill[2] = 1'b0;
        run_frame(0);

        // frame_start in DISPATCH is ignored; reset in WAIT and mid-walk.
        hook = 4;
        run_frame(0);
        repeat (3) @(negedge clk);
        check("no_second_frame", {run_valid, frame_done}, 0);
        setvec(9, 16'h0900);
        hook = 3;
        run_frame(0);
        run_frame(0);
        chan_valid = 1'b1; chan_first = '0; chan_last = 6'd63; chan_type = 2'd2;
        @(negedge clk);
        chan_valid = 1'b0;
        @(negedge clk);
        check("walk_busy_before_reset", chan_busy, 1);
        reset = 1'b0;
        #1;
        check("rst_walk_busy", chan_busy, 0);
        check("rst_walk_ready", setvec_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        run_frame(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
